card_select_ctrl: RTL

- Converts mouse clicks into card selections for the 8x18 card grid drawn by the display stage.
- Maps the mouse pixel to a grid cell, checks the cell's card code in the map, and toggles that position's bit in the registered sel_card vector.
- sel_card feeds the display's selection highlight.
- Sits directly upstream of the display top, alongside the mouse and game-state logic.

---
 rtl/card_select_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/card_select_ctrl.sv
// Click-to-card selection for the 8x18 card grid; toggles sel_card bits.
// Optional SEL_LIMIT_EN macro caps the number of selected cards at MAX_SEL.
module card_select_ctrl #(
  parameter int unsigned X0          = 32,
  parameter int unsigned CARD_W_LOG2 = 5,
  parameter int unsigned COLS        = 18,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned TOP_Y0      = 19,
  parameter int unsigned BOT_Y0      = 360,
  parameter int unsigned TOP_ROWS    = 6,
  parameter int unsigned PITCH       = 55,
  parameter int unsigned CARD_H      = 46,
  parameter int unsigned EMPTY_CODE  = 0,
  parameter int unsigned MAX_SEL     = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         interboard_rst,
  input  logic         en,
  input  logic         click,
  input  logic         clear_sel,
  input  logic [9:0]   mouse_x,
  input  logic [9:0]   mouse_y,
  input  logic [863:0] map,
  output logic [143:0] sel_card,
  output logic [7:0]   sel_cnt,
  output logic         busy,
  output logic         hit_valid,
  output logic [7:0]   hit_idx,
  output logic         miss
);

  typedef enum logic [2:0] {
    IDLE, SCAN, LOOKUP, UPDATE, MISS
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [9:0]   r_y;
  logic [9:0]   r_top;
  logic [4:0]   r_col;
  logic [2:0]   r_row;
  logic [7:0]   r_idx;
  logic [5:0]   r_code;
  logic [143:0] r_sel_card;
  logic [7:0]   r_sel_cnt;
  logic [7:0]   r_hit_idx;

  logic         w_clr;
  logic         w_start;
  logic         w_x_ok;
  logic [9:0]   w_xoff;
  logic         w_row_hit;
  logic [7:0]   w_idx;
  logic [9:0]   w_base;
  logic         w_cur;
  logic         w_block;
  logic         w_hit;

  assign w_clr   = clear_sel | interboard_rst;
  assign w_start = click & en & ~w_clr;
  assign w_x_ok  = (mouse_x >= 10'(X0)) &&
                   (mouse_x < 10'(X0 + (COLS << CARD_W_LOG2)));
  assign w_xoff  = mouse_x - 10'(X0);

  assign w_row_hit = (r_y >= r_top) &&
                     (r_y < r_top + 10'(CARD_H));
  // row*18 built from shifts: row*16 + row*2
  assign w_idx = 8'({r_row, 4'b0000}) +
                 8'({r_row, 1'b0}) + 8'(r_col);
  assign w_base = ({2'b00, r_idx} << 2) +
                  ({2'b00, r_idx} << 1);
  assign w_cur  = r_sel_card[r_idx];

`ifdef SEL_LIMIT_EN
  assign w_block = !w_cur && (r_sel_cnt == 8'(MAX_SEL));
`else
  assign w_block = 1'b0;
`endif

  assign w_hit = (r_code != 6'(EMPTY_CODE)) && !w_block;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != IDLE);
    hit_valid = 1'b0;
    miss      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = w_x_ok ? SCAN : MISS;
      end
      SCAN: begin
        if (w_row_hit)
          w_next = LOOKUP;
        else if (r_row == 3'(ROWS - 1))
          w_next = MISS;
      end
      LOOKUP: w_next = UPDATE;
      UPDATE: begin
        w_next    = IDLE;
        hit_valid = w_hit;
        miss      = !w_hit;
      end
      MISS: begin
        w_next = IDLE;
        miss   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
    if (w_clr) begin
      w_next    = IDLE;
      hit_valid = 1'b0;
      miss      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y        <= '0;
      r_top      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_idx      <= '0;
      r_code     <= '0;
      r_sel_card <= '0;
      r_sel_cnt  <= '0;
      r_hit_idx  <= '0;
    end else if (w_clr) begin
      r_sel_card <= '0;
      r_sel_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_y   <= mouse_y;
            r_col <= w_xoff[9:CARD_W_LOG2];
            r_row <= '0;
            r_top <= 10'(TOP_Y0);
          end
        end
        SCAN: begin
          if (w_row_hit) begin
            r_idx <= w_idx;
          end else begin
            r_row <= r_row + 3'd1;
            // lower band restarts at its own origin
            r_top <= (r_row == 3'(TOP_ROWS - 1)) ?
                     10'(BOT_Y0) : r_top + 10'(PITCH);
          end
        end
        LOOKUP: r_code <= map[w_base +: 6];
        UPDATE: begin
          if (w_hit) begin
            r_hit_idx         <= r_idx;
            r_sel_card[r_idx] <= !w_cur;
            r_sel_cnt <= w_cur ? r_sel_cnt - 8'd1
                               : r_sel_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel_card = r_sel_card;
  assign sel_cnt  = r_sel_cnt;
  assign hit_idx  = r_hit_idx;

endmodule
